fifo_prog: RTL and testbench
============================

FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 32, entry count; it must be a power of two and at least 4.
REQ-003 The block SHALL have parameter FWFT, default 0; 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-004 The block SHALL derive constant AW = clog2(DEPTH); counts are AW+1 bits wide.
REQ-005 The block SHALL have these ports:
  clk  in  1  rising-edge clock for all state.
  sync_reset_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
  wr_en  in  1  write request.
  wr_data  in  WIDTH  write data.
  rd_en  in  1  read request.
  rd_data  out  WIDTH  read data.
  rd_valid  out  1  rd_data holds a read word.
  af_thresh  in  AW+1  almost-full threshold, sampled every cycle.
  ae_thresh  in  AW+1  almost-empty threshold, sampled every cycle.
  level  out  AW+1  current occupancy, 0..DEPTH.
  full, empty  out  1  occupancy flags.
  almost_full, almost_empty  out  1  threshold flags.
  overflow, underflow  out  1  sticky error flags.
  clr_err  in  1  clears the sticky error flags.

Function
REQ-006 A write SHALL be accepted iff wr_en=1 and full=0; the accepted word is stored at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-007 A read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr advances modulo DEPTH.
REQ-008 A write SHALL be rejected while full=1, even if a read is accepted in the same cycle.
REQ-009 level SHALL be a registered counter: +1 on a write-only accept, -1 on a read-only accept, unchanged on both or neither.
REQ-010 The level counter SHALL never leave the range 0..DEPTH.
REQ-011 The flags SHALL be combinational from level: full = (level==DEPTH), empty = (level==0), almost_full = (level >= af_thresh), almost_empty = (level <= ae_thresh).
REQ-012 In FWFT=0 mode, rd_data SHALL be registered: the word at the old rd_ptr is loaded on an accepted read, rd_valid=1 in the following cycle only, and rd_data holds its value otherwise.
REQ-013 In FWFT=1 mode, rd_data SHALL equal mem[rd_ptr] and rd_valid SHALL equal !empty; an accepted read exposes the next entry in the following cycle.
REQ-014 In FWFT=1 mode, a word written into an empty FIFO SHALL appear on rd_data with rd_valid=1 one cycle after the write.
REQ-015 On simultaneous write and read accepts with 0<level<DEPTH, both pointers SHALL advance and level SHALL be unchanged.
REQ-016 overflow SHALL be set on the cycle after wr_en=1 while full=1, and SHALL hold until cleared.
REQ-017 underflow SHALL be set on the cycle after rd_en=1 while empty=1, and SHALL hold until cleared.
REQ-018 clr_err=1 SHALL clear overflow and underflow; a new error in the same cycle wins and the flag stays set.
REQ-019 Rejected requests SHALL NOT change the pointers, level, memory or rd_data.
REQ-020 Threshold changes SHALL affect almost_full and almost_empty in the same cycle.

Reset
REQ-021 sync_reset_n=0 at a clk edge SHALL set wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, rd_data=0 (FWFT=0), overflow=0 and underflow=0.
REQ-022 Reset SHALL take priority over all requests in the same cycle, and all stored data is discarded.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 After reset, the outputs SHALL be empty=1, full=0, and almost_empty=1 when ae_thresh>=0.
REQ-025 A reset asserted mid-operation SHALL drop any pending rd_valid pulse.

Structure
REQ-026 A shared package fifo_pkg SHALL hold the FWFT mode constants (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1) and the AW/count-width helper function.
REQ-027 Storage SHALL be one sub-module, fifo_ram: a DEPTH x WIDTH simple dual-port memory with a synchronous write port and an asynchronous read port.
REQ-028 Pointer, level, flag and error logic SHALL reside in fifo_prog.

Verification (WIDTH=8, DEPTH=8)
REQ-029 Fill and drain: write 0x01..0x08, then read 8 -> full=1 after the 8th write and level=8; reads return 0x01..0x08 in order; empty=1 at the end.
REQ-030 Wrap-around: repeat 5 writes and 5 reads 4 times -> all 20 words are returned in order, and level peaks at 5.
REQ-031 Overflow: at level=8, hold wr_en=1 and rd_en=1 for one cycle -> the read is accepted, the write is rejected, level=7, overflow=1; clr_err then gives overflow=0.
REQ-032 Underflow and clear conflict: from empty, rd_en=1 together with clr_err=1 -> underflow=1 and level stays 0.
REQ-033 Thresholds: af_thresh=6, ae_thresh=2, write 6 words -> almost_empty drops after the 3rd write; almost_full rises after the 6th; af_thresh changed to 7 -> almost_full=0 in the same cycle.
REQ-034 Mode and reset: FWFT=1, write 0xA5 into an empty FIFO -> rd_data=0xA5 with rd_valid=1 the next cycle; sync_reset_n=0 at level=3 -> level=0, empty=1, rd_valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the programmable FIFO slice.
//   FIFO_MODE_REG  : rd_data is registered and loaded on an accepted read
//   FIFO_MODE_FWFT : rd_data shows the head entry whenever the FIFO is non-empty
//   fifo_aw()      : pointer width for a given depth
//   fifo_cnt_w()   : occupancy/threshold width (one bit wider than the pointer
//                    so that the value DEPTH can be represented)
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_aw(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_prog_if.sv
// -----------------------------------------------------------------------------
// fifo_prog_if
// Bundles the write/read request signals, thresholds and status outputs of
// fifo_prog. clk and sync_reset_n are kept as plain module ports.
//   master : the client side (drives requests, thresholds, clr_err)
//   slave  : the FIFO side (drives read data, level and flags)
//
// Handshake: a write is taken on a rising clk edge when wr_en=1 and full=0;
// a read is taken when rd_en=1 and empty=0. full/empty act as the ready
// signals and are valid in the same cycle as the request, so a request held
// high is retried every cycle until it is accepted. Requests made against the
// flag set (write while full, read while empty) are dropped and latched in
// the sticky overflow/underflow flags until clr_err.
// -----------------------------------------------------------------------------
interface fifo_prog_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   import fifo_pkg::*;

   localparam int CW = fifo_cnt_w(DEPTH);

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [CW-1:0]    af_thresh;
   logic [CW-1:0]    ae_thresh;
   logic [CW-1:0]    level;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;
   logic             clr_err;

   modport master (
      output wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
      input  rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
      output rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

endinterface

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// -----------------------------------------------------------------------------
// fifo_prog
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a choice of registered-read or
// first-word-fall-through output.
//   clk          : rising-edge clock for all state
//   sync_reset_n : synchronous active-low reset (pointers, level, read output,
//                  error flags; storage is left untouched)
//   fifo_bus     : fifo_prog_if.slave -- requests, thresholds, data and flags
// Parameters: WIDTH (bits per entry), DEPTH (power of two, >= 4),
//             FWFT (FIFO_MODE_REG or FIFO_MODE_FWFT).
// -----------------------------------------------------------------------------
module fifo_prog
   import fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int FWFT  = FIFO_MODE_REG
) (
   input  logic       clk,
   input  logic       sync_reset_n,
   fifo_prog_if.slave fifo_bus
);

   localparam int            AW       = fifo_aw(DEPTH);
   localparam int            CW       = fifo_cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             full, empty;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] ram_rdata;

   // Flags come straight from the registered level; thresholds are compared
   // combinationally so a threshold change shows up without a clock.
   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);

   // A write is refused whenever full, even if a read frees a slot this cycle.
   assign wr_acc = fifo_bus.wr_en && !full;
   assign rd_acc = fifo_bus.rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      // DEPTH is a power of two, so pointer wrap is plain binary rollover.
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (wr_acc && !rd_acc) begin
         level_d = level_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         level_d = level_q - CW'(1);
      end

      // A fresh error outranks clr_err in the same cycle.
      ovf_d = (fifo_bus.wr_en && full)  || (ovf_q && !fifo_bus.clr_err);
      unf_d = (fifo_bus.rd_en && empty) || (unf_q && !fifo_bus.clr_err);
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Writes are suppressed during reset so a request coinciding with reset
   // cannot leave anything behind.
   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_acc && sync_reset_n),
      .waddr_i (wr_ptr_q),
      .wdata_i (fifo_bus.wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // The head entry is always presented; a read simply moves rd_ptr on.
      assign fifo_bus.rd_data  = ram_rdata;
      assign fifo_bus.rd_valid = !empty;
   end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q, rd_valid_d;

      always_comb begin
         rd_data_d  = rd_data_q;
         rd_valid_d = rd_acc;
         if (rd_acc) begin
            rd_data_d = ram_rdata;
         end
      end

      always_ff @(posedge clk) begin
         if (!sync_reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign fifo_bus.rd_data  = rd_data_q;
      assign fifo_bus.rd_valid = rd_valid_q;
   end

   assign fifo_bus.level        = level_q;
   assign fifo_bus.full         = full;
   assign fifo_bus.empty        = empty;
   assign fifo_bus.almost_full  = (level_q >= fifo_bus.af_thresh);
   assign fifo_bus.almost_empty = (level_q <= fifo_bus.ae_thresh);
   assign fifo_bus.overflow     = ovf_q;
   assign fifo_bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_prog
// Drives a registered-read and a first-word-fall-through instance of fifo_prog
// (WIDTH=8, DEPTH=8) with identical stimulus and checks both against a
// queue-based reference model, a hand-written vector table and directed
// corner-case sequences.
// -----------------------------------------------------------------------------
module tb_fifo_prog;
   import fifo_pkg::*;

   localparam int W = 8;
   localparam int D = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rstn;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus variables ----------------
   logic         wr_en_t, rd_en_t, clr_t;
   logic [W-1:0] wdata_t;
   logic [3:0]   af_th, ae_th;

   fifo_prog_if #(.WIDTH(W), .DEPTH(D)) b0 ();
   fifo_prog_if #(.WIDTH(W), .DEPTH(D)) b1 ();

   assign b0.wr_en = wr_en_t;   assign b1.wr_en = wr_en_t;
   assign b0.wr_data = wdata_t; assign b1.wr_data = wdata_t;
   assign b0.rd_en = rd_en_t;   assign b1.rd_en = rd_en_t;
   assign b0.clr_err = clr_t;   assign b1.clr_err = clr_t;
   assign b0.af_thresh = af_th; assign b1.af_thresh = af_th;
   assign b0.ae_thresh = ae_th; assign b1.ae_thresh = ae_th;

   fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(FIFO_MODE_REG)) u_reg (
      .clk(clk), .sync_reset_n(rstn), .fifo_bus(b0));
   fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(FIFO_MODE_FWFT)) u_fwft (
      .clk(clk), .sync_reset_n(rstn), .fifo_bus(b1));

   // ---------------- reference model ----------------
   logic [W-1:0] model_q[$];
   logic         m_ovf, m_unf, m_rv;
   logic [W-1:0] m_rd;

   // scoreboard for ordered read-back
   logic [W-1:0] exp_q[$];

   int n_vec = 0;
   int n_bad = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Behaviour of one clock edge expressed on a plain queue.
   function automatic void model_edge(bit rst_n_v, bit wr_v, bit rd_v, bit clr_v,
                                      logic [W-1:0] d_v);
      bit was_full, was_empty;
      if (!rst_n_v) begin
         model_q.delete();
         m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
         return;
      end
      was_full  = (model_q.size() == D);
      was_empty = (model_q.size() == 0);
      m_rv = rd_v && !was_empty;
      if (m_rv) m_rd = model_q.pop_front();
      if (wr_v && !was_full) model_q.push_back(d_v);
      m_ovf = (wr_v && was_full)  || (m_ovf && !clr_v);
      m_unf = (rd_v && was_empty) || (m_unf && !clr_v);
   endfunction

   function automatic void check_model();
      int lvl;
      lvl = model_q.size();
      chk("reg_level", b0.level, lvl);
      chk("fwft_level", b1.level, lvl);
      chk("reg_full", b0.full, lvl == D);
      chk("fwft_full", b1.full, lvl == D);
      chk("reg_empty", b0.empty, lvl == 0);
      chk("fwft_empty", b1.empty, lvl == 0);
      chk("reg_af", b0.almost_full, lvl >= int'(af_th));
      chk("fwft_af", b1.almost_full, lvl >= int'(af_th));
      chk("reg_ae", b0.almost_empty, lvl <= int'(ae_th));
      chk("fwft_ae", b1.almost_empty, lvl <= int'(ae_th));
      chk("reg_ovf", b0.overflow, m_ovf);
      chk("fwft_ovf", b1.overflow, m_ovf);
      chk("reg_unf", b0.underflow, m_unf);
      chk("fwft_unf", b1.underflow, m_unf);
      chk("reg_rv", b0.rd_valid, m_rv);
      chk("reg_rd", b0.rd_data, m_rd);
      chk("fwft_rv", b1.rd_valid, lvl != 0);
      if (lvl != 0) chk("fwft_rd", b1.rd_data, model_q[0]);
   endfunction

   // ---------------- driver ----------------
   task automatic step(input bit rst_n_v, input bit wr_v, input bit rd_v,
                       input bit clr_v, input logic [W-1:0] d_v);
      rstn = rst_n_v; wr_en_t = wr_v; rd_en_t = rd_v; clr_t = clr_v; wdata_t = d_v;
      @(posedge clk);
      model_edge(rst_n_v, wr_v, rd_v, clr_v, d_v);
      #1;
      check_model();
      rstn = 1'b1; wr_en_t = 1'b0; rd_en_t = 1'b0; clr_t = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit           rst_n, wr, rd, clr;
      logic [W-1:0] d;
      logic [3:0]   af, ae;
      int           lvl;
      bit           full, empty, afl, ael, ovf, unf, rv;
      logic [W-1:0] rd_data;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int peak;
      int got;

      rstn = 1'b0; wr_en_t = 1'b0; rd_en_t = 1'b0; clr_t = 1'b0; wdata_t = '0;
      af_th = 4'd6; ae_th = 4'd2;
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;

      //            rst wr rd clr  d      af ae | lvl full emp af ae ovf unf rv  rd (registered mode)
      tbl[0]  = '{0, 0, 0, 0, 8'h00, 6, 2, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00};
      tbl[1]  = '{1, 0, 1, 1, 8'h00, 6, 2, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00};
      tbl[2]  = '{1, 0, 0, 1, 8'h00, 6, 2, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00};
      tbl[3]  = '{1, 1, 0, 0, 8'h11, 6, 2, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00};
      tbl[4]  = '{1, 1, 0, 0, 8'h22, 6, 2, 2, 0, 0, 0, 1, 0, 0, 0, 8'h00};
      tbl[5]  = '{1, 1, 1, 0, 8'h33, 6, 2, 2, 0, 0, 0, 1, 0, 0, 1, 8'h11};
      tbl[6]  = '{1, 0, 1, 0, 8'h00, 6, 2, 1, 0, 0, 0, 1, 0, 0, 1, 8'h22};
      tbl[7]  = '{1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h22};
      tbl[8]  = '{1, 0, 1, 0, 8'h00, 6, 2, 0, 0, 1, 0, 1, 0, 0, 1, 8'h33};
      tbl[9]  = '{1, 0, 1, 0, 8'h00, 6, 2, 0, 0, 1, 0, 1, 0, 1, 0, 8'h33};
      tbl[10] = '{1, 1, 1, 0, 8'h44, 6, 2, 1, 0, 0, 0, 1, 0, 1, 0, 8'h33};
      tbl[11] = '{0, 1, 0, 0, 8'h55, 6, 2, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00};

      for (int i = 0; i < 12; i++) begin
         af_th = tbl[i].af; ae_th = tbl[i].ae;
         step(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d);
         chk($sformatf("tbl%0d_level", i), b0.level, tbl[i].lvl);
         chk($sformatf("tbl%0d_full", i), b0.full, tbl[i].full);
         chk($sformatf("tbl%0d_empty", i), b0.empty, tbl[i].empty);
         chk($sformatf("tbl%0d_af", i), b0.almost_full, tbl[i].afl);
         chk($sformatf("tbl%0d_ae", i), b0.almost_empty, tbl[i].ael);
         chk($sformatf("tbl%0d_ovf", i), b0.overflow, tbl[i].ovf);
         chk($sformatf("tbl%0d_unf", i), b0.underflow, tbl[i].unf);
         chk($sformatf("tbl%0d_rv", i), b0.rd_valid, tbl[i].rv);
         chk($sformatf("tbl%0d_rd", i), b0.rd_data, tbl[i].rd_data);
         chk($sformatf("tbl%0d_fwft_level", i), b1.level, tbl[i].lvl);
         chk($sformatf("tbl%0d_fwft_unf", i), b1.underflow, tbl[i].unf);
      end

      // ---- fill and drain ----
      af_th = 4'd6; ae_th = 4'd2;
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, W'(i));
      chk("fill_full", b0.full, 1);
      chk("fill_level", b0.level, 8);
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 1, 0, 0);
         chk("drain_rv", b0.rd_valid, 1);
         chk("drain_data", b0.rd_data, i);
      end
      chk("drain_empty", b0.empty, 1);

      // ---- overflow with simultaneous read, then clear ----
      for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, W'(8'h80 + i));
      step(1, 1, 1, 0, 8'hEE);
      chk("ovf_level", b0.level, 7);
      chk("ovf_flag", b0.overflow, 1);
      chk("ovf_rd", b0.rd_data, 8'h81);
      step(1, 0, 0, 1, 0);
      chk("ovf_clr", b0.overflow, 0);
      for (int i = 2; i <= 8; i++) begin
         step(1, 0, 1, 0, 0);
         chk("ovf_drain", b0.rd_data, 8'h80 + i);
      end
      chk("ovf_drop_empty", b0.empty, 1);

      // ---- wrap-around with ordered scoreboard ----
      peak = 0; got = 0;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 5; k++) begin
            logic [W-1:0] v;
            v = W'($urandom_range(255));
            exp_q.push_back(v);
            step(1, 1, 0, 0, v);
            if (int'(b0.level) > peak) peak = int'(b0.level);
         end
         for (int k = 0; k < 5; k++) begin
            step(1, 0, 1, 0, 0);
            if (b0.rd_valid === 1'b1 && exp_q.size() > 0) begin
               chk("wrap_data", b0.rd_data, exp_q.pop_front());
               got++;
            end
         end
      end
      chk("wrap_peak", peak, 5);
      chk("wrap_count", got, 20);

      // ---- thresholds ----
      step(0, 0, 0, 0, 0);
      af_th = 4'd6; ae_th = 4'd2;
      for (int k = 1; k <= 6; k++) begin
         step(1, 1, 0, 0, W'(k));
         chk("th_ae", b0.almost_empty, k <= 2);
         chk("th_af", b0.almost_full, k >= 6);
      end
      af_th = 4'd7;
      #1;
      chk("th_af_comb", b0.almost_full, 0);
      chk("th_af_comb_fwft", b1.almost_full, 0);

      // ---- FWFT write-through and reset mid-operation ----
      step(0, 0, 0, 0, 0);
      af_th = 4'd6; ae_th = 4'd2;
      step(1, 1, 0, 0, 8'hA5);
      chk("fwft_a5_data", b1.rd_data, 8'hA5);
      chk("fwft_a5_valid", b1.rd_valid, 1);
      step(1, 1, 0, 0, 8'h5A);
      step(1, 1, 1, 0, 8'h3C);
      chk("pre_rst_level", b1.level, 2);
      step(1, 1, 0, 0, 8'hC3);
      chk("pre_rst_level3", b0.level, 3);
      step(0, 0, 1, 0, 0);
      chk("rst_level", b1.level, 0);
      chk("rst_empty", b1.empty, 1);
      chk("rst_rv_fwft", b1.rd_valid, 0);
      chk("rst_rv_reg", b0.rd_valid, 0);

      // ---- randomized run against the model ----
      for (int ph = 0; ph < 10; ph++) begin
         int wr_pct;
         wr_pct = $urandom_range(20, 80);
         for (int c = 0; c < 200; c++) begin
            bit rs, wv, rv, cv;
            if ($urandom_range(15) == 0) begin
               af_th = 4'($urandom_range(D));
               ae_th = 4'($urandom_range(D));
            end
            rs = ($urandom_range(99) != 0);
            wv = ($urandom_range(99) < wr_pct);
            rv = ($urandom_range(99) < (100 - wr_pct));
            cv = ($urandom_range(19) == 0);
            step(rs, wv, rv, cv, W'($urandom_range(255)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
